calc_core: RTL and testbench

Parametrised keypad-driven decimal calculator core for the next-generation calculator top. It accepts debounced single-cycle key pulses for digits, add/subtract, equals and clear, and holds two operands of up to `DIGITS` decimal digits. On equals it computes a signed result, converts it back to BCD with an iterative double-dabble unit, and drives per-digit BCD values plus blanking flags for the display layer. It replaces the hard-wired 2-digit add-only sequencing in the board top level.

---
 rtl/calc_core_pkg.sv | 23 ++
 rtl/calc_core_if.sv | 27 ++
 rtl/calc_core_bin_to_bcd.sv | 70 +++++++
 rtl/calc_core.sv | 234 +++++++++++++++++++++++
 tb/tb_calc_core.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/calc_core_pkg.sv
// Shared types for the keypad calculator core: FSM state and operator
// encodings, plus the display blanking polarity.
package calc_core_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_A_ENTRY = 3'd1,
    S_OP_WAIT = 3'd2,
    S_B_ENTRY = 3'd3,
    S_CONVERT = 3'd4,
    S_RESULT  = 3'd5
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // A set blank flag turns the digit off.
  localparam logic       BLANK_OFF = 1'b1;
  localparam logic [3:0] MAX_DIGIT = 4'd9;

endpackage

// File: rtl/calc_core_if.sv
// Key-pulse inputs and display outputs of the calculator core, grouped as
// one bundle; master is the keypad/display side, slave is the core.
interface calc_core_if #(parameter int DIGITS = 2);

  logic                      i_Key_Valid;
  logic [3:0]                i_Key_Digit;
  logic                      i_Op_Add;
  logic                      i_Op_Sub;
  logic                      i_Equals;
  logic                      i_Clear;
  logic [4*(DIGITS+1)-1:0]   o_Disp_Bcd;
  logic [DIGITS:0]           o_Disp_Blank;
  logic                      o_Negative;
  logic                      o_Busy;
  logic [2:0]                o_State;

  modport master (
    output i_Key_Valid, i_Key_Digit, i_Op_Add, i_Op_Sub, i_Equals, i_Clear,
    input  o_Disp_Bcd, o_Disp_Blank, o_Negative, o_Busy, o_State
  );

  modport slave (
    input  i_Key_Valid, i_Key_Digit, i_Op_Add, i_Op_Sub, i_Equals, i_Clear,
    output o_Disp_Bcd, o_Disp_Blank, o_Negative, o_Busy, o_State
  );

endinterface

// File: rtl/calc_core_bin_to_bcd.sv
// Iterative double-dabble binary-to-BCD converter: one load cycle on i_Start,
// then one shift per input bit; o_Done pulses after the last shift.
module bin_to_bcd_dd #(
  parameter int W  = 8,
  parameter int ND = 3
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic            i_Clr,
  input  logic            i_Start,
  input  logic [W-1:0]    i_Bin,
  output logic [4*ND-1:0] o_Bcd,
  output logic            o_Done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]    r_bin;
  logic [4*ND-1:0] r_bcd;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [4*ND-1:0] w_adj;

  function automatic logic [4*ND-1:0] dabble(input logic [4*ND-1:0] v);
    for (int i = 0; i < ND; i++) begin
      if (v[4*i +: 4] >= 4'd5) v[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return v;
  endfunction

  assign w_adj = dabble(r_bcd);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_Clr) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_Start) begin
      r_bin  <= i_Bin;
      r_bcd  <= '0;
      r_cnt  <= CW'(W);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      // Adjust every nibble >= 5 before shifting the next binary bit in.
      r_bcd <= {w_adj[4*ND-2:0], r_bin[W-1]};
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_Bcd  = r_bcd;
  assign o_Done = r_done;

endmodule

// File: rtl/calc_core.sv
// Keypad-driven decimal calculator: two operands of up to DIGITS digits,
// add/subtract with sign, result converted to BCD for the display layer.
module calc_core
  import calc_core_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int OPW    = $clog2(10**DIGITS),
  parameter int RW     = $clog2(2*10**DIGITS - 1)
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  calc_core_if.slave bus
);

  localparam int             ND    = DIGITS + 1;
  localparam int             BW    = 4 * ND;
  localparam int             AW    = 4 * DIGITS;
  localparam logic [RW-1:0]  MAXOP = RW'(10**DIGITS - 1);

  state_t          r_state, w_next;
  logic [OPW-1:0]  r_a, r_b;
  logic [AW-1:0]   r_a_bcd, r_b_bcd;
  logic [2:0]      r_cnt;
  op_t             r_op;
  logic [RW-1:0]   r_mag;
  logic            r_sign;
  logic [BW-1:0]   r_res_bcd;

  logic [BW-1:0]   r_disp_bcd;
  logic [ND-1:0]   r_disp_blank;
  logic            r_neg, r_busy;
  logic [2:0]      r_state_o;

  logic            w_clr, w_eq, w_add, w_sub, w_op, w_dig;
  op_t             w_opc;
  logic [3:0]      w_d;
  logic [RW-1:0]   w_a_ext, w_b_ext, w_mag;
  logic            w_b_gt, w_sign, w_chain_ok, w_start;
  logic [OPW-1:0]  w_cur_val, w_app_val;
  logic [AW-1:0]   w_cur_bcd, w_app_bcd;
  logic [2:0]      w_app_cnt;
  logic            w_ent_zero, w_app_ok;
  logic [BW-1:0]   w_dd_bcd;
  logic            w_dd_done;
  logic [BW-1:0]   w_disp_bcd;
  logic [ND-1:0]   w_disp_blank;
  logic            w_neg, w_busy;

  function automatic logic [ND-1:0] lead_blank(input logic [BW-1:0] v);
    logic [ND-1:0] b;
    logic          lead;
    b    = '0;
    lead = 1'b1;
    for (int i = ND - 1; i >= 1; i--) begin
      if (v[4*i +: 4] != 4'd0) lead = 1'b0;
      b[i] = lead ? BLANK_OFF : ~BLANK_OFF;
    end
    b[0] = ~BLANK_OFF;
    return b;
  endfunction

  // Only the highest-priority pulse of a cycle acts.
  assign w_clr = bus.i_Clear;
  assign w_eq  = bus.i_Equals & ~w_clr;
  assign w_add = bus.i_Op_Add & ~w_clr & ~w_eq;
  assign w_sub = bus.i_Op_Sub & ~w_clr & ~w_eq & ~w_add;
  assign w_op  = w_add | w_sub;
  assign w_opc = w_add ? OP_ADD : OP_SUB;
  assign w_d   = bus.i_Key_Digit;
  assign w_dig = bus.i_Key_Valid & (w_d <= MAX_DIGIT) & ~w_clr & ~w_eq & ~w_op;

  assign w_a_ext    = RW'(r_a);
  assign w_b_ext    = RW'(r_b);
  assign w_b_gt     = w_b_ext > w_a_ext;
  assign w_mag      = (r_op == OP_ADD) ? w_a_ext + w_b_ext :
                      (w_b_gt ? w_b_ext - w_a_ext : w_a_ext - w_b_ext);
  assign w_sign     = (r_op == OP_SUB) & w_b_gt & (w_mag != '0);
  assign w_chain_ok = ~r_sign & (r_mag <= MAXOP);
  assign w_start    = (r_state == S_B_ENTRY) & w_eq;

  // An operand of 0 is replaced rather than extended, so no leading zeros.
  assign w_cur_val  = (r_state == S_B_ENTRY) ? r_b : r_a;
  assign w_cur_bcd  = (r_state == S_B_ENTRY) ? r_b_bcd : r_a_bcd;
  assign w_ent_zero = (w_cur_val == '0);
  assign w_app_val  = w_ent_zero ? OPW'(w_d) : w_cur_val * OPW'(10) + OPW'(w_d);
  assign w_app_bcd  = w_ent_zero ? AW'(w_d) : AW'({w_cur_bcd, w_d});
  assign w_app_cnt  = w_ent_zero ? 3'd1 : r_cnt + 3'd1;
  assign w_app_ok   = w_ent_zero | (r_cnt < 3'(DIGITS));

  bin_to_bcd_dd #(.W(RW), .ND(ND)) u_dd (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Clr   (w_clr),
    .i_Start (w_start),
    .i_Bin   (w_mag),
    .o_Bcd   (w_dd_bcd),
    .o_Done  (w_dd_done)
  );

  // State register; outputs are registered from the current state, so the
  // display trails the state by one cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state      <= S_IDLE;
      r_disp_bcd   <= '0;
      r_disp_blank <= {ND{BLANK_OFF}};
      r_neg        <= 1'b0;
      r_busy       <= 1'b0;
      r_state_o    <= S_IDLE;
    end else begin
      r_state      <= w_next;
      r_disp_bcd   <= w_disp_bcd;
      r_disp_blank <= w_disp_blank;
      r_neg        <= w_neg;
      r_busy       <= w_busy;
      r_state_o    <= r_state;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_clr) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_dig) w_next = S_A_ENTRY;
        S_A_ENTRY: if (w_op) w_next = S_OP_WAIT;
        S_OP_WAIT: if (w_dig) w_next = S_B_ENTRY;
        S_B_ENTRY: if (w_eq) w_next = S_CONVERT;
        S_CONVERT: if (w_dd_done) w_next = S_RESULT;
        S_RESULT: begin
          if (w_dig)                   w_next = S_A_ENTRY;
          else if (w_op && w_chain_ok) w_next = S_OP_WAIT;
        end
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_disp_bcd   = '0;
    w_disp_blank = {ND{BLANK_OFF}};
    w_neg        = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_A_ENTRY, S_OP_WAIT: begin
        w_disp_bcd   = BW'(r_a_bcd);
        w_disp_blank = lead_blank(BW'(r_a_bcd));
      end
      S_B_ENTRY: begin
        w_disp_bcd   = BW'(r_b_bcd);
        w_disp_blank = lead_blank(BW'(r_b_bcd));
      end
      S_CONVERT: w_busy = 1'b1;
      S_RESULT: begin
        w_disp_bcd   = r_res_bcd;
        w_disp_blank = lead_blank(r_res_bcd);
        w_neg        = r_sign;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n || w_clr) begin
      r_a       <= '0;
      r_b       <= '0;
      r_a_bcd   <= '0;
      r_b_bcd   <= '0;
      r_cnt     <= '0;
      r_op      <= OP_ADD;
      r_mag     <= '0;
      r_sign    <= 1'b0;
      r_res_bcd <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_dig) begin
          r_a     <= OPW'(w_d);
          r_a_bcd <= AW'(w_d);
          r_cnt   <= 3'd1;
        end
        S_A_ENTRY: begin
          if (w_dig && w_app_ok) begin
            r_a     <= w_app_val;
            r_a_bcd <= w_app_bcd;
            r_cnt   <= w_app_cnt;
          end else if (w_op) begin
            r_op <= w_opc;
          end
        end
        S_OP_WAIT: begin
          if (w_dig) begin
            r_b     <= OPW'(w_d);
            r_b_bcd <= AW'(w_d);
            r_cnt   <= 3'd1;
          end else if (w_op) begin
            r_op <= w_opc;
          end
        end
        S_B_ENTRY: begin
          if (w_eq) begin
            r_mag  <= w_mag;
            r_sign <= w_sign;
          end else if (w_dig && w_app_ok) begin
            r_b     <= w_app_val;
            r_b_bcd <= w_app_bcd;
            r_cnt   <= w_app_cnt;
          end
        end
        S_CONVERT: if (w_dd_done) r_res_bcd <= w_dd_bcd;
        S_RESULT: begin
          if (w_dig) begin
            r_a     <= OPW'(w_d);
            r_a_bcd <= AW'(w_d);
            r_cnt   <= 3'd1;
          end else if (w_op && w_chain_ok) begin
            r_a     <= OPW'(r_mag);
            r_a_bcd <= r_res_bcd[AW-1:0];
            r_cnt   <= 3'(DIGITS);
            r_op    <= w_opc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_Disp_Bcd   = r_disp_bcd;
  assign bus.o_Disp_Blank = r_disp_blank;
  assign bus.o_Negative   = r_neg;
  assign bus.o_Busy       = r_busy;
  assign bus.o_State      = r_state_o;

endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core (DIGITS=2): key sequences with hand-computed
// display values, equals latency, clear/priority and asynchronous reset.
module tb_calc_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  calc_core_if #(.DIGITS(2)) bus ();

  calc_core #(.DIGITS(2)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic show(input string tag, input logic [11:0] bcd, input logic [2:0] blank,
                      input logic neg, input logic [2:0] st);
    chk({tag, ".bcd"},   32'(bus.o_Disp_Bcd),   32'(bcd));
    chk({tag, ".blank"}, 32'(bus.o_Disp_Blank), 32'(blank));
    chk({tag, ".neg"},   32'(bus.o_Negative),   32'(neg));
    chk({tag, ".state"}, 32'(bus.o_State),      32'(st));
    chk({tag, ".busy"},  32'(bus.o_Busy),       32'd0);
  endtask

  // Called at a falling edge: hold the pulse for one rising edge, then let
  // the registered display settle for one more cycle.
  task automatic press(input logic kv, input logic [3:0] d, input logic add,
                       input logic sub, input logic eq, input logic clr);
    bus.i_Key_Valid = kv;
    bus.i_Key_Digit = d;
    bus.i_Op_Add    = add;
    bus.i_Op_Sub    = sub;
    bus.i_Equals    = eq;
    bus.i_Clear     = clr;
    @(negedge clk);
    bus.i_Key_Valid = 1'b0;
    bus.i_Key_Digit = 4'd0;
    bus.i_Op_Add    = 1'b0;
    bus.i_Op_Sub    = 1'b0;
    bus.i_Equals    = 1'b0;
    bus.i_Clear     = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_equals(input string tag);
    int   busy_n;
    logic got;
    busy_n = 0;
    got    = 1'b0;
    bus.i_Equals = 1'b1;
    @(negedge clk);
    bus.i_Equals = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.o_Busy) busy_n++;
      if (bus.o_State == 3'd5) got = 1'b1;
    end
    chk({tag, ".reached"}, 32'(got), 32'd1);
    chk({tag, ".busy_cycles"}, 32'(busy_n), 32'd9);
  endtask

  task automatic keys(input string s);
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      case (c)
        "+":     press(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        "-":     press(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        "=":     do_equals(s);
        "C":     press(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        default: press(1'b1, 4'(c - 8'd48), 1'b0, 1'b0, 1'b0, 1'b0);
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    bus.i_Key_Valid = 1'b0;
    bus.i_Key_Digit = 4'd0;
    bus.i_Op_Add    = 1'b0;
    bus.i_Op_Sub    = 1'b0;
    bus.i_Equals    = 1'b0;
    bus.i_Clear     = 1'b0;
    repeat (3) @(negedge clk);
    show("reset", 12'h000, 3'b111, 1'b0, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    keys("42");
    show("a_42", 12'h042, 3'b100, 1'b0, 3'd1);
    keys("+");
    show("opwait", 12'h042, 3'b100, 1'b0, 3'd2);
    keys("7");
    show("b_7", 12'h007, 3'b110, 1'b0, 3'd3);
    keys("=");
    show("res_49", 12'h049, 3'b100, 1'b0, 3'd5);

    keys("C");
    show("clear", 12'h000, 3'b111, 1'b0, 3'd0);
    keys("15-38=");
    show("res_neg23", 12'h023, 3'b100, 1'b1, 3'd5);
    keys("+");
    show("chain_neg_ignored", 12'h023, 3'b100, 1'b1, 3'd5);
    keys("1");
    show("new_a_1", 12'h001, 3'b110, 1'b0, 3'd1);

    keys("C99+99=");
    show("res_198", 12'h198, 3'b000, 1'b0, 3'd5);
    keys("C007");
    show("lead_zero", 12'h007, 3'b110, 1'b0, 3'd1);
    keys("C123");
    show("digit_limit", 12'h012, 3'b100, 1'b0, 3'd1);

    keys("C12+3=");
    show("res_15", 12'h015, 3'b100, 1'b0, 3'd5);
    keys("-");
    show("chain_a", 12'h015, 3'b100, 1'b0, 3'd2);
    keys("5=");
    show("res_10", 12'h010, 3'b100, 1'b0, 3'd5);
    keys("5-5=");
    show("res_zero", 12'h000, 3'b110, 1'b0, 3'd5);

    // Clear sampled three rising edges after equals.
    keys("C12+3");
    bus.i_Equals = 1'b1;
    @(negedge clk);
    bus.i_Equals = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("conv.busy_before_clear", 32'(bus.o_Busy), 32'd1);
    keys("C");
    show("clr_conv", 12'h000, 3'b111, 1'b0, 3'd0);
    keys("5+5=");
    show("after_abort", 12'h010, 3'b100, 1'b0, 3'd5);

    keys("C4");
    press(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    show("clr_beats_digit", 12'h000, 3'b111, 1'b0, 3'd0);
    keys("6");
    press(1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    show("bad_digit", 12'h006, 3'b110, 1'b0, 3'd1);

    keys("C1+2");
    show("b_entry", 12'h002, 3'b110, 1'b0, 3'd3);
    #2 rst_n = 1'b0;
    #1 show("async_rst", 12'h000, 3'b111, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    keys("3");
    show("after_rst", 12'h003, 3'b110, 1'b0, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
